// File: rtl/isa_program_loader.sv
// rtl/isa_program_loader.sv - packs field-level instructions into 16-bit words and writes them to instruction RAM
// Optional checksum output enabled by defining LOADER_CHECKSUM_EN.
module isa_program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        f_opcode,
    input  logic [1:0]        f_op,
    input  logic [2:0]        f_rn,
    input  logic [2:0]        f_rd,
    input  logic [2:0]        f_rm,
    input  logic [1:0]        f_shift,
    input  logic [7:0]        f_imm,
    input  logic [2:0]        f_cond,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              illegal,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   count
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr;
    logic              full;
    logic              wr_en_q;
    logic              illegal_q;
    logic [DATA_W-1:0] enc;
    logic              legal;
    logic              is_halt;
    logic              accept;
    logic              restart;

    assign accept  = in_valid && in_ready;
    assign restart = start && (state_q != S_LOAD);

    always_comb begin
        enc     = '0;
        legal   = 1'b0;
        is_halt = 1'b0;
        case (f_opcode)
            3'b110: begin
                if (f_op == 2'b10) begin
                    enc   = {3'b110, 2'b10, f_rn, f_imm};
                    legal = 1'b1;
                end else if (f_op == 2'b00) begin
                    enc   = {3'b110, 2'b00, 3'b000, f_rd, f_shift, f_rm};
                    legal = 1'b1;
                end
            end
            3'b101: begin
                // CMP has no destination, MVN has no first operand
                enc   = {3'b101, f_op,
                         (f_op == 2'b11) ? 3'b000 : f_rn,
                         (f_op == 2'b01) ? 3'b000 : f_rd,
                         f_shift, f_rm};
                legal = 1'b1;
            end
            3'b011: begin
                enc   = {3'b011, 2'b00, f_rn, f_rd, f_imm[4:0]};
                legal = (f_op == 2'b00);
            end
            3'b100: begin
                enc   = {3'b100, 2'b00, f_rn, f_rd, f_imm[4:0]};
                legal = (f_op == 2'b00);
            end
            3'b001: begin
                enc   = {3'b001, 2'b00, f_cond, f_imm};
                legal = (f_op == 2'b00) && (f_cond == 3'b000);
            end
            3'b111: begin
                enc     = {3'b111, 13'b0};
                legal   = 1'b1;
                is_halt = 1'b1;
            end
            default: begin
                enc   = '0;
                legal = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_ready = !full;
                busy     = 1'b1;
                if (accept && legal && is_halt) begin
                    state_d = S_DONE;
                end else if (full && in_valid) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            full      <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            illegal_q <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            count     <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            wr_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            // done trails the DONE state by one cycle and drops as soon as a restart is taken
            done      <= (state_q == S_DONE) && !start;
            if (restart) begin
                ptr      <= base_addr;
                full     <= 1'b0;
                count    <= '0;
                overflow <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                checksum <= '0;
`endif
            end else if (state_q == S_LOAD) begin
                if (accept) begin
                    if (legal) begin
                        wr_en_q <= 1'b1;
                        wr_addr <= ptr;
                        wr_data <= enc;
                        count   <= count + CNT_ONE;
`ifdef LOADER_CHECKSUM_EN
                        checksum <= checksum + enc;
`endif
                        // the pointer parks on the last address instead of wrapping
                        if (ptr == LAST_ADDR) begin
                            full <= 1'b1;
                        end else begin
                            ptr <= ptr + PTR_ONE;
                        end
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end else if (full && in_valid) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    // a reset arriving while a write is pending must not reach the RAM
    assign wr_en   = wr_en_q && !rst;
    assign illegal = illegal_q && !rst;

endmodule
